// File: rtl/mem_access.sv
// Memory-access stage: byte-serial loads/stores over a req/ack port, with a pipeline stall
// while the access runs and sign/zero extension of load results toward MEM/WB.
module mem_access #(
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  we_in,
  input  logic [4:0]            waddr_in,
  input  logic [31:0]           wdata_in,
  input  logic                  ma_we,
  input  logic                  ma_re,
  input  logic [2:0]            ma_width,
  input  logic [31:0]           ma_addr,
  input  logic [31:0]           ma_wdata,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_dout,
  input  logic [7:0]            mem_din,
  input  logic                  mem_ack,
  output logic                  we,
  output logic [4:0]            waddr,
  output logic [31:0]           wdata,
  output logic                  stall_req
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              idx_q;
  logic [31:0]             buf_q;
  logic                    lat_we_q;
  logic [4:0]              lat_waddr_q;
  logic [2:0]              lat_width_q;
  logic [ADDR_WIDTH-1:0]   lat_addr_q;
  logic [31:0]             lat_wdata_q;
  logic                    lat_store_q;

  logic                    mem_op;
  logic [1:0]              last_idx;
  logic                    sext;
  logic [31:0]             load_ext;

  assign mem_op = ma_we | ma_re;
  assign sext   = ~lat_width_q[2];

  // Upper address bits beyond the memory port are intentionally dropped.
  if (ADDR_WIDTH < 32) begin : g_unused_addr
    logic unused_addr_hi;
    assign unused_addr_hi = ^ma_addr[31:ADDR_WIDTH];
  end

  // Index of the final byte of the latched access (N-1).
  always_comb begin
    last_idx = lat_width_q[1] ? 2'd3 : {1'b0, lat_width_q[0]};
  end

  // State register; rdy=0 freezes the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (mem_op) state_d = StAccess;
      StAccess: if (mem_ack && (idx_q == last_idx)) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Request latch, byte index and load buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= 2'd0;
      buf_q       <= 32'h0;
      lat_we_q    <= 1'b0;
      lat_waddr_q <= 5'd0;
      lat_width_q <= 3'd0;
      lat_addr_q  <= '0;
      lat_wdata_q <= 32'h0;
      lat_store_q <= 1'b0;
    end else if (rdy) begin
      if (state_q == StIdle && mem_op) begin
        idx_q       <= 2'd0;
        lat_we_q    <= we_in;
        lat_waddr_q <= waddr_in;
        lat_width_q <= ma_width;
        lat_addr_q  <= ma_addr[ADDR_WIDTH-1:0];
        lat_wdata_q <= ma_wdata;
        lat_store_q <= ma_we;  // store wins when both are requested
      end else if (state_q == StAccess && mem_ack) begin
        if (!lat_store_q) begin
          buf_q[8*idx_q +: 8] <= mem_din;
        end
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  // Load extension; buffer bytes beyond the access width are discarded here.
  always_comb begin
    unique case (lat_width_q[1:0])
      2'b00:   load_ext = {{24{sext & buf_q[7]}}, buf_q[7:0]};
      2'b01:   load_ext = {{16{sext & buf_q[15]}}, buf_q[15:0]};
      default: load_ext = buf_q;
    endcase
  end

  // Outputs; held at zero while reset is asserted, including the IDLE pass-through.
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_dout  = 8'h0;
    we        = 1'b0;
    waddr     = 5'd0;
    wdata     = 32'h0;
    stall_req = 1'b0;
    if (rst) begin
      unique case (state_q)
        StIdle: begin
          if (mem_op) begin
            stall_req = 1'b1;
          end else begin
            we    = we_in;
            waddr = waddr_in;
            wdata = wdata_in;
          end
        end
        StAccess: begin
          mem_req   = rdy;
          mem_wr    = lat_store_q;
          mem_addr  = lat_addr_q + ADDR_WIDTH'(idx_q);
          mem_dout  = lat_wdata_q[8*idx_q +: 8];
          stall_req = 1'b1;
        end
        StDone: begin
          we    = lat_we_q;
          waddr = lat_waddr_q;
          wdata = lat_store_q ? 32'h0 : load_ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a scoreboard of expected bytes and writeback results.
module tb_mem_access;

  localparam int AW = 17;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [7:0]    dout;
  } byte_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          we_in;
  logic [4:0]    waddr_in;
  logic [31:0]   wdata_in;
  logic          ma_we;
  logic          ma_re;
  logic [2:0]    ma_width;
  logic [31:0]   ma_addr;
  logic [31:0]   ma_wdata;
  logic          mem_req;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_dout;
  logic [7:0]    mem_din;
  logic          mem_ack;
  logic          we;
  logic [4:0]    waddr;
  logic [31:0]   wdata;
  logic          stall_req;

  byte_t exp_bytes[$];
  res_t  exp_res[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  mem_access #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .we_in     (we_in),
    .waddr_in  (waddr_in),
    .wdata_in  (wdata_in),
    .ma_we     (ma_we),
    .ma_re     (ma_re),
    .ma_width  (ma_width),
    .ma_addr   (ma_addr),
    .ma_wdata  (ma_wdata),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_ack   (mem_ack),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one memory op, push its expected bytes/result, then service it and compare.
  task automatic run_op(input string tag, input logic st, input logic ld, input logic [2:0] w,
                        input logic [31:0] addr, input logic [31:0] wd, input logic wein,
                        input logic [4:0] wa, input logic [31:0] din, input int delay,
                        input int freeze_at);
    int          n, k, waits, stalls, cyc;
    bit          done, frozen;
    byte_t       b;
    res_t        r;
    logic [31:0] res;
    n = w[1] ? 4 : (w[0] ? 2 : 1);
    @(negedge clk);
    ma_we = st; ma_re = ld; ma_width = w; ma_addr = addr; ma_wdata = wd;
    we_in = wein; waddr_in = wa; wdata_in = 32'h0BAD_F00D; mem_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      b.addr = addr[AW-1:0] + AW'(i);
      b.wr   = st;
      b.dout = wd[8*i +: 8];
      exp_bytes.push_back(b);
    end
    if (st) res = 32'h0;
    else begin
      case (w)
        3'b000:  res = {{24{din[7]}}, din[7:0]};
        3'b001:  res = {{16{din[15]}}, din[15:0]};
        3'b100:  res = {24'h0, din[7:0]};
        3'b101:  res = {16'h0, din[15:0]};
        default: res = din;
      endcase
    end
    r.we = wein; r.waddr = wa; r.wdata = res;
    exp_res.push_back(r);
    #1;
    chk({tag, "_entry_stall"}, stall_req, 1);
    chk({tag, "_entry_we"}, we, 0);
    chk({tag, "_entry_req"}, mem_req, 0);
    stalls = 1; k = 0; waits = 0; cyc = 0; done = 0; frozen = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (k == freeze_at && !frozen) begin
        frozen = 1;
        repeat (3) begin
          rdy = 1'b0; mem_ack = 1'b1; mem_din = 8'hEE;
          #1;
          chk({tag, "_frz_req"}, mem_req, 0);
          chk({tag, "_frz_addr"}, mem_addr, exp_bytes[0].addr);
          if (stall_req) stalls++;
          @(negedge clk);
        end
        rdy = 1'b1; mem_ack = 1'b0;
      end
      #1;
      cyc++;
      if (mem_req) begin
        if (stall_req) stalls++;
        if (waits == delay) begin
          b = exp_bytes.pop_front();
          chk({tag, "_addr"}, mem_addr, b.addr);
          chk({tag, "_wr"}, mem_wr, b.wr);
          chk({tag, "_dout"}, mem_dout, b.dout);
          mem_ack = 1'b1;
          mem_din = din[8*k +: 8];
          k++;
          waits = 0;
        end else begin
          waits++;
        end
      end else begin
        done = 1;
        r = exp_res.pop_front();
        chk({tag, "_stall_done"}, stall_req, 0);
        chk({tag, "_we"}, we, r.we);
        chk({tag, "_waddr"}, waddr, r.waddr);
        chk({tag, "_wdata"}, wdata, r.wdata);
        chk({tag, "_nbytes"}, k, n);
        chk({tag, "_stalls"}, stalls, 1 + n * (delay + 1) + (freeze_at >= 0 ? 3 : 0));
        ma_we = 1'b0; ma_re = 1'b0; we_in = 1'b1; waddr_in = 5'd17; wdata_in = 32'h5A5A_0001;
      end
    end
    chk({tag, "_finished"}, done, 1);
    // DONE lasts one cycle: next cycle is IDLE pass-through.
    @(negedge clk);
    #1;
    chk({tag, "_post_idle_wdata"}, wdata, 32'h5A5A_0001);
    chk({tag, "_post_idle_stall"}, stall_req, 0);
    we_in = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1;
    we_in = 1'b1; waddr_in = 5'd7; wdata_in = 32'hDEAD_BEEF;
    ma_we = 1'b0; ma_re = 1'b0; ma_width = 3'b010; ma_addr = 32'h0; ma_wdata = 32'h0;
    mem_din = 8'h0; mem_ack = 1'b0;
    #12;
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_req", mem_req, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1. non-memory pass-through
    we_in = 1'b1; waddr_in = 5'd5; wdata_in = 32'h1234;
    #1;
    chk("pass_we", we, 1);
    chk("pass_waddr", waddr, 5);
    chk("pass_wdata", wdata, 32'h1234);
    chk("pass_stall", stall_req, 0);
    chk("pass_req", mem_req, 0);

    // 2. LW, zero-wait acks
    run_op("lw", 0, 1, 3'b010, 32'h100, 32'hCAFE_F00D, 1, 5'd3, 32'h1234_5678, 0, -1);
    // 3. LB / LBU / LH / LHU
    run_op("lb", 0, 1, 3'b000, 32'h21, 32'h0, 1, 5'd4, 32'h0000_0080, 0, -1);
    run_op("lbu", 0, 1, 3'b100, 32'h21, 32'h0, 1, 5'd4, 32'h0000_0080, 0, -1);
    run_op("lh", 0, 1, 3'b001, 32'h21, 32'h0, 1, 5'd6, 32'hAAAA_FFFE, 0, -1);
    run_op("lhu", 0, 1, 3'b101, 32'h1FFFF, 32'h0, 1, 5'd8, 32'h7777_9ABC, 1, -1);
    // 4. SH with wrap and 2-cycle ack delay; SW; both-flags store
    run_op("sh", 1, 0, 3'b001, 32'h0001_FFFF, 32'hAABB_CCDD, 0, 5'd0, 32'h0, 2, -1);
    run_op("sw", 1, 0, 3'b010, 32'h0002_0042, 32'h0102_0304, 0, 5'd0, 32'h0, 0, -1);
    run_op("sb_both", 1, 1, 3'b000, 32'h55, 32'h0000_00A5, 0, 5'd0, 32'hFFFF_FFFF, 0, -1);
    // 5. rdy low mid-access with ack pulses
    run_op("lw_frz", 0, 1, 3'b010, 32'h40, 32'h0, 1, 5'd10, 32'h1122_3344, 0, 1);

    // 6. reset during the second byte of a LW
    @(negedge clk);
    ma_re = 1'b1; ma_width = 3'b010; ma_addr = 32'h200; we_in = 1'b1; waddr_in = 5'd9;
    wdata_in = 32'h7;
    @(negedge clk);
    mem_ack = 1'b1; mem_din = 8'h01;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("rst_mid_pre_req", mem_req, 1);
    chk("rst_mid_pre_addr", mem_addr, 17'h201);
    rst = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_stall", stall_req, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_wr_dout", {mem_wr, mem_dout}, 0);
    chk("rst_mid_wb", {we, waddr, wdata}, 0);
    @(negedge clk);
    ma_re = 1'b0; rst = 1'b1;
    #1;
    chk("rst_rel_idle_stall", stall_req, 0);
    chk("rst_rel_idle_wdata", wdata, 32'h7);
    run_op("lb_after_rst", 0, 1, 3'b000, 32'h30, 32'h0, 1, 5'd12, 32'h0000_0085, 0, -1);

    chk("sb_bytes_empty", exp_bytes.size(), 0);
    chk("sb_res_empty", exp_res.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
